// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith ops plus iterative MUL/DIV.
// Ports: clk, reset_n (async low); in_valid/in_ready + opcode/operand1/operand2
//        request side; out_valid/out_ready + result/flags{Z,N,C,V}/div_by_zero
//        result side; busy is high whenever the FSM is not idle.
module multicycle_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_ROL  = 4'h6;
    localparam logic [3:0] OP_ROR  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_XNOR = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 div_q, div_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic [3:0]           flg_q, flg_d;
    logic                 dbz_q, dbz_d;

    function automatic logic [3:0] mk_flags(
        input logic [WIDTH-1:0] r,
        input logic             c,
        input logic             v
    );
        return {(r == '0), r[WIDTH-1], c, v};
    endfunction

    // Single-cycle datapath, evaluated on the live request inputs.
    logic [WIDTH:0]   add_w, sub_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_dbz;
    logic             a_msb, b_msb;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_dbz = 1'b0;
        a_msb   = operand1[WIDTH-1];
        b_msb   = operand2[WIDTH-1];
        add_w   = {1'b0, operand1} + {1'b0, operand2};
        sub_w   = {1'b0, operand1} - {1'b0, operand2};
        case (opcode)
            OP_ADD: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (a_msb == b_msb) && (add_w[WIDTH-1] != a_msb);
            end
            OP_SUB: begin
                alu_res = sub_w[WIDTH-1:0];
                // Borrow out of the extended subtract equals a < b.
                alu_c   = sub_w[WIDTH];
                alu_v   = (a_msb != b_msb) && (sub_w[WIDTH-1] != a_msb);
            end
            OP_MUL: alu_res = '0;
            OP_DIV: begin
                alu_res = '1;
                alu_dbz = (operand2 == '0);
            end
            OP_SHL: begin
                alu_res = {operand1[WIDTH-2:0], 1'b0};
                alu_c   = a_msb;
            end
            OP_SHR: begin
                alu_res = {1'b0, operand1[WIDTH-1:1]};
                alu_c   = operand1[0];
            end
            OP_ROL: begin
                alu_res = {operand1[WIDTH-2:0], a_msb};
                alu_c   = a_msb;
            end
            OP_ROR: begin
                alu_res = {operand1[0], operand1[WIDTH-1:1]};
                alu_c   = operand1[0];
            end
            OP_AND:  alu_res = operand1 & operand2;
            OP_OR:   alu_res = operand1 | operand2;
            OP_XOR:  alu_res = operand1 ^ operand2;
            OP_NOR:  alu_res = ~(operand1 | operand2);
            OP_NAND: alu_res = ~(operand1 & operand2);
            OP_XNOR: alu_res = ~(operand1 ^ operand2);
            OP_GT:   alu_res = {{(WIDTH-1){1'b0}}, (operand1 > operand2)};
            default: alu_res = {{(WIDTH-1){1'b0}}, (operand1 == operand2)};
        endcase
    end

    // Iteration step. acc holds {hi, lo}:
    //   MUL: hi = partial product, lo = multiplier shifting out right.
    //   DIV: hi = remainder, lo = dividend shifting out / quotient in.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh, diff;
    logic [2*WIDTH-1:0] mul_next, div_next, step;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff     = rem_sh - {1'b0, b_q};
        // Negative trial difference: restore (keep shifted remainder), bit 0.
        div_next = diff[WIDTH]
                 ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                 : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        step     = div_q ? div_next : mul_next;
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        flg_d   = flg_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cnt_d = '0;
                    div_d = (opcode == OP_DIV);
                    b_d   = operand2;
                    acc_d = {{WIDTH{1'b0}}, operand1};
                    if ((opcode == OP_MUL) ||
                        ((opcode == OP_DIV) && (operand2 != '0))) begin
                        state_d = EXEC;
                    end else begin
                        state_d = DONE;
                        res_d   = alu_res;
                        flg_d   = mk_flags(alu_res, alu_c, alu_v);
                        dbz_d   = alu_dbz;
                    end
                end
            end
            EXEC: begin
                acc_d = step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    res_d   = step[WIDTH-1:0];
                    flg_d   = mk_flags(step[WIDTH-1:0],
                                       !div_q && (|step[2*WIDTH-1:WIDTH]),
                                       1'b0);
                    dbz_d   = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            div_q   <= 1'b0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign result      = res_q;
    assign flags       = flg_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu (WIDTH=16): directed corner cases,
// stall/reset scenarios and randomized traffic against an arithmetic model.
module tb_multicycle_alu;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    opcode;
    logic [W-1:0]  operand1, operand2;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [3:0]    flags;
    logic          div_by_zero;
    logic          busy;

    logic rdy_cmd, rand_en, rnd_rdy;
    assign out_ready = rand_en ? rnd_rdy : rdy_cmd;

    multicycle_alu #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .operand1(operand1), .operand2(operand2),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags),
        .div_by_zero(div_by_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   flg;
        logic         dbz;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   seen    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    function automatic int sx(input logic [W-1:0] v);
        return v[W-1] ? int'(v) - 65536 : int'(v);
    endfunction

    // Reference model: plain integer arithmetic on the opcode meaning.
    function automatic exp_t model(input logic [3:0] op,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t        e;
        logic [31:0] p;
        logic [W-1:0] r;
        logic        c, v;
        int          sr;
        c = 1'b0; v = 1'b0; r = '0;
        e.dbz = 1'b0; e.lat = 1; e.acc = 0;
        case (op)
            4'h0: begin
                p = a + b; r = p[15:0]; c = p[16];
                sr = sx(a) + sx(b); v = (sr > 32767) || (sr < -32768);
            end
            4'h1: begin
                r = a - b; c = (a < b);
                sr = sx(a) - sx(b); v = (sr > 32767) || (sr < -32768);
            end
            4'h2: begin
                p = a * b; r = p[15:0]; c = (p[31:16] != 0); e.lat = 17;
            end
            4'h3: begin
                if (b == 0) begin r = 16'hFFFF; e.dbz = 1'b1; end
                else begin r = a / b; e.lat = 17; end
            end
            4'h4: begin r = a << 1; c = a[15]; end
            4'h5: begin r = a >> 1; c = a[0]; end
            4'h6: begin r = (a << 1) | (a >> 15); c = a[15]; end
            4'h7: begin r = (a >> 1) | (a << 15); c = a[0]; end
            4'h8: r = a & b;
            4'h9: r = a | b;
            4'hA: r = a ^ b;
            4'hB: r = ~(a | b);
            4'hC: r = ~(a & b);
            4'hD: r = ~(a ^ b);
            4'hE: r = (a > b) ? 16'd1 : 16'd0;
            default: r = (a == b) ? 16'd1 : 16'd0;
        endcase
        e.res = r;
        e.flg = {(r == 0), r[15], c, v};
        return e;
    endfunction

    // Monitor: pops the scoreboard on the first cycle a result is shown.
    always @(negedge clk) begin
        rnd_rdy = ($urandom_range(0, 3) != 0);
        if (reset_n && out_valid && !seen) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got result %0h, required none",
                         result);
            end else begin
                mon_e = sb.pop_front();
                check("result", result, mon_e.res);
                check("flags", flags, mon_e.flg);
                check("div_by_zero", div_by_zero, mon_e.dbz);
                check("latency", cyc - mon_e.acc + 1, mon_e.lat);
            end
        end else if (reset_n && !out_valid && sb.size() != 0 &&
                     cyc >= sb[0].acc) begin
            check("busy_in_flight", busy, 1);
            check("in_ready_in_flight", in_ready, 0);
        end
        seen = out_valid;
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        exp_t e;
        int   t;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: got in_ready 0, required 1");
        end else begin
            e = model(op, a, b);
            e.acc = cyc + 1;
            sb.push_back(e);
            last_exp = e;
            in_valid = 1'b1;
            opcode   = op;
            operand1 = a;
            operand2 = b;
            @(negedge clk);
            in_valid = 1'b0;
            opcode   = 4'($urandom);
            operand1 = W'($urandom);
            operand2 = W'($urandom);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sb.size() != 0 || !in_ready) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0 || !in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: got %0d pending, required 0",
                     sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]   op;
        logic [W-1:0] a, b;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        opcode   = '0;
        operand1 = '0;
        operand2 = '0;
        rdy_cmd  = 1'b1;
        rand_en  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        issue(4'h0, 16'hFFFF, 16'h0001); wait_idle();
        issue(4'h2, 16'd300, 16'd300);   wait_idle();
        issue(4'h3, 16'd100, 16'd7);     wait_idle();
        issue(4'h3, 16'd5, 16'd0);       wait_idle();
        issue(4'h1, 16'h8000, 16'h0001); wait_idle();
        issue(4'h1, 16'h0000, 16'h0001); wait_idle();

        // Consumer stall in DONE with a competing request on the input.
        rdy_cmd = 1'b0;
        issue(4'hA, 16'h1234, 16'h00FF);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", out_valid, 1);
            check("stall_result", result, last_exp.res);
            check("stall_flags", flags, last_exp.flg);
            check("stall_in_ready", in_ready, 0);
            in_valid = 1'b1;
            opcode   = 4'h0;
            operand1 = W'($urandom);
            operand2 = W'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rdy_cmd  = 1'b1;
        @(negedge clk);
        check("release_in_ready", in_ready, 1);
        check("release_out_valid", out_valid, 0);
        wait_idle();

        // Reset in the middle of a multiply.
        issue(4'h2, 16'd300, 16'd300);
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("abort_busy", busy, 0);
        reset_n = 1'b1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        repeat (20) @(negedge clk);
        check("abort_no_result", out_valid, 0);
        issue(4'h8, 16'h0F0F, 16'h00FF); wait_idle();

        // Random back-to-back traffic with a randomly stalling consumer.
        rand_en = 1'b1;
        for (int n = 0; n < 150; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = pick();
            b  = pick();
            if (op == 4'h3 && $urandom_range(0, 4) == 0) b = '0;
            issue(op, a, b);
        end
        wait_idle();
        rand_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter: WIDTH, default 16, operand/result width; legal range 4..64.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  request present.
REQ-005 SHALL have port: in_ready  output  1  block can accept a request.
REQ-006 SHALL have port: opcode  input  4  operation select, encoding per REQ-012.
REQ-007 SHALL have ports: operand1, operand2  input  WIDTH  source operands.
REQ-008 SHALL have port: out_valid  output  1  result available.
REQ-009 SHALL have port: out_ready  input  1  consumer takes result.
REQ-010 SHALL have ports: result  output  WIDTH; flags  output  4  {Z,N,C,V}; div_by_zero  output  1; busy  output  1  (state != IDLE).

Function
REQ-011 SHALL implement FSM IDLE -> EXEC (MUL/DIV only) -> DONE -> IDLE; in_ready = 1 only in IDLE.
REQ-012 SHALL decode opcodes: 0 ADD, 1 SUB, 2 MUL, 3 DIV (unsigned quotient), 4 SHL1, 5 SHR1 (logical), 6 ROL1, 7 ROR1, 8 AND, 9 OR, A XOR, B NOR, C NAND, D XNOR, E GT (unsigned, 1/0), F EQ (1/0).
REQ-013 SHALL capture opcode and both operands on the handshake (in_valid & in_ready); later input changes SHALL NOT affect the operation in flight.
REQ-014 SHALL complete every opcode other than MUL/DIV in one cycle: IDLE -> DONE, out_valid high on the edge after acceptance.
REQ-015 SHALL compute MUL by iterative shift-add, one operand bit per cycle, WIDTH cycles in EXEC; out_valid rises WIDTH+1 edges after acceptance; result = low WIDTH bits of the product.
REQ-016 SHALL compute DIV by restoring division, one quotient bit per cycle, WIDTH cycles in EXEC; latency WIDTH+1 edges; result = quotient; remainder discarded.
REQ-017 SHALL handle DIV with operand2 == 0 without entering EXEC: result all ones, div_by_zero = 1, latency 1.
REQ-018 SHALL hold result, flags and div_by_zero stable in DONE while out_valid & !out_ready; SHALL return to IDLE on the edge where out_valid & out_ready.
REQ-019 SHALL ignore in_valid while not in IDLE (no queuing); back-to-back throughput is one request per (latency + 1) cycles minimum.
REQ-020 SHALL set Z = (result == 0) and N = result[WIDTH-1] for all opcodes.
REQ-021 SHALL set C as follows: ADD carry-out; SUB borrow (operand1 < operand2 unsigned); SHL1/ROL1 old MSB; SHR1/ROR1 old LSB; MUL 1 if any upper-half product bit is set; all other opcodes 0.
REQ-022 SHALL set V as signed two's-complement overflow for ADD/SUB and 0 for all other opcodes.
REQ-023 SHALL clear div_by_zero for every operation except the case in REQ-017.
REQ-024 SHALL reset the iteration counter at every acceptance; the counter width SHALL be ceil(log2(WIDTH+1)).

Reset
REQ-025 SHALL, while reset_n = 0, force state IDLE, with out_valid, result, flags, div_by_zero, busy = 0 and internal accumulators/counter = 0; in_ready SHALL be 1 immediately after reset_n deasserts.
REQ-026 SHALL abort any EXEC/DONE operation on reset assertion; no result from the aborted operation SHALL appear after reset release.

Verification (WIDTH=16)
REQ-027 SHALL verify: ADD 0xFFFF + 0x0001 -> result 0x0000, Z=1, C=1, V=0, out_valid one edge after acceptance.
REQ-028 SHALL verify: MUL 300 * 300 -> result 0x5F90, C=1, out_valid 17 edges after acceptance, in_ready=0 and busy=1 throughout.
REQ-029 SHALL verify: DIV 100 / 7 -> 0x000E at latency 17; DIV 5 / 0 -> 0xFFFF with div_by_zero=1 at latency 1.
REQ-030 SHALL verify: SUB 0x8000 - 0x0001 -> 0x7FFF, V=1, C=0; SUB 0x0000 - 0x0001 -> 0xFFFF, N=1, C=1.
REQ-031 SHALL verify: out_ready held low 5 cycles in DONE -> result/flags unchanged, in_ready=0, a new in_valid is ignored; after out_ready=1 -> IDLE next edge.
REQ-032 SHALL verify: reset_n pulsed low during MUL iteration 8 -> out_valid=0 and in_ready=1 after release; a following AND 0x0F0F & 0x00FF -> 0x000F.
